// File: rtl/priority_encoder_4to2.sv
// priority_encoder_4to2
//   Registered 4-to-2 priority encoder with request capture and a
//   valid/acknowledge handshake. Requests on D0..D3 are latched into a
//   pending set. One pending index is presented on A1A0 with V. The index
//   is held until ACK, then the next pending request is presented.
//
// Parameters
//   ROUND_ROBIN : 0 = fixed priority (D3 highest, D0 lowest)
//                 1 = rotating priority, search starts after last grant
//
// Ports
//   CLK     in   clock, rising edge
//   RST     in   asynchronous active-high reset
//   G       in   capture enable for D0..D3
//   D0..D3  in   request lines
//   ACK     in   consumer accepts current index (ignored while V=0)
//   A0, A1  out  encoded index (registered)
//   V       out  A1A0 is a valid pending index (registered)
//   OVF     out  one-cycle pulse: captured request was already pending
module priority_encoder_4to2 #(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic G,
  input  logic D0,
  input  logic D1,
  input  logic D2,
  input  logic D3,
  input  logic ACK,
  output logic A0,
  output logic A1,
  output logic V,
  output logic OVF
);

  logic [3:0] p_q;
  logic [1:0] a_q;
  logic [1:0] last_q;
  logic       v_q;
  logic       ovf_q;

  logic [3:0] clr;
  logic [3:0] set;
  logic [3:0] p_nxt;
  logic       ovf_nxt;
  logic [1:0] win;
  logic       adv;

  always_comb begin
    clr     = (v_q && ACK) ? (4'b0001 << a_q) : 4'b0000;
    set     = G ? {D3, D2, D1, D0} : 4'b0000;
    // set after clear: a re-request of the index being acked stays pending
    p_nxt   = (p_q & ~clr) | set;
    ovf_nxt = |(set & p_q & ~clr);
    // the presented index may only move when nothing is on display or the
    // consumer has just taken it
    adv     = !v_q || ACK;
  end

  // Winner of p_nxt. Only meaningful when p_nxt != 0.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    win   = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    if (ROUND_ROBIN) begin
      // search last+1, last+2, ... wrapping mod 4; i=4 revisits last itself
      for (int i = 1; i <= 4; i++) begin
        idx = last_q + 2'(i);
        if (!found && p_nxt[idx]) begin
          found = 1'b1;
          win   = idx;
        end
      end
    end else begin
      if      (p_nxt[3]) win = 2'd3;
      else if (p_nxt[2]) win = 2'd2;
      else if (p_nxt[1]) win = 2'd1;
      else               win = 2'd0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p_q    <= 4'b0000;
      a_q    <= 2'b00;
      v_q    <= 1'b0;
      ovf_q  <= 1'b0;
      last_q <= 2'b11;   // first RR search order becomes 0,1,2,3
    end else begin
      p_q   <= p_nxt;
      ovf_q <= ovf_nxt;
      if (adv) begin
        if (|p_nxt) begin
          v_q <= 1'b1;
          a_q <= win;
          if (ROUND_ROBIN) last_q <= win;
        end else begin
          v_q <= 1'b0;   // A keeps its last value
        end
      end
    end
  end

  assign A0  = a_q[0];
  assign A1  = a_q[1];
  assign V   = v_q;
  assign OVF = ovf_q;

endmodule

// File: tb/tb_priority_encoder_4to2.sv
// Bench for priority_encoder_4to2. A fixed-priority and a round-robin
// instance share the same stimulus. Each directed step pushes the expected
// {V,A1,A0,OVF} of both instances into a scoreboard queue; a monitor pops
// one entry per clock, 1 time unit after the rising edge, and compares.
module tb_priority_encoder_4to2;

  logic CLK = 1'b0;
  logic RST;
  logic G, D0, D1, D2, D3, ACK;
  logic fx_a0, fx_a1, fx_v, fx_ovf;
  logic rr_a0, rr_a1, rr_v, rr_ovf;

  int n_chk  = 0;
  int n_fail = 0;
  int step_no = 0;

  typedef struct {
    int         id;
    logic [3:0] fx;   // {V,A1,A0,OVF}
    logic [3:0] rr;
  } exp_t;

  exp_t sb[$];

  always #5 CLK = ~CLK;

  priority_encoder_4to2 #(.ROUND_ROBIN(1'b0)) dut_fx (
    .CLK(CLK), .RST(RST), .G(G), .D0(D0), .D1(D1), .D2(D2), .D3(D3),
    .ACK(ACK), .A0(fx_a0), .A1(fx_a1), .V(fx_v), .OVF(fx_ovf)
  );

  priority_encoder_4to2 #(.ROUND_ROBIN(1'b1)) dut_rr (
    .CLK(CLK), .RST(RST), .G(G), .D0(D0), .D1(D1), .D2(D2), .D3(D3),
    .ACK(ACK), .A0(rr_a0), .A1(rr_a1), .V(rr_v), .OVF(rr_ovf)
  );

  task automatic chk(input string nm, input int id, input logic [3:0] got,
                     input logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got V,A1,A0,OVF=%b required %b", nm, id, got, exp);
    end
  endtask

  // monitor: one scoreboard entry per clock edge
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("fixed", e.id, {fx_v, fx_a1, fx_a0, fx_ovf}, e.fx);
      chk("rrobin", e.id, {rr_v, rr_a1, rr_a0, rr_ovf}, e.rr);
    end
  end

  // drive one cycle of inputs and queue what both instances must show after it
  task automatic step(input logic g, input logic [3:0] d, input logic ack,
                      input logic [3:0] efx, input logic [3:0] err);
    exp_t e;
    step_no++;
    G = g; {D3, D2, D1, D0} = d; ACK = ack;
    e.id = step_no; e.fx = efx; e.rr = err;
    sb.push_back(e);
    @(posedge CLK);
    #2;
  endtask

  initial begin
    RST = 1'b1; G = 1'b0; {D3, D2, D1, D0} = 4'b0000; ACK = 1'b0;
    #1;
    chk("reset_fx", 0, {fx_v, fx_a1, fx_a0, fx_ovf}, 4'b0000);
    chk("reset_rr", 0, {rr_v, rr_a1, rr_a0, rr_ovf}, 4'b0000);
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;

    //    G   D3..D0  ACK   fx {V,A,OVF}  rr {V,A,OVF}
    // drain all four with ACK held
    step(1, 4'b1111, 1, 4'b1_11_0, 4'b1_00_0);
    step(1, 4'b0000, 1, 4'b1_10_0, 4'b1_01_0);
    step(1, 4'b0000, 1, 4'b1_01_0, 4'b1_10_0);
    step(1, 4'b0000, 1, 4'b1_00_0, 4'b1_11_0);
    step(1, 4'b0000, 1, 4'b0_00_0, 4'b0_11_0);
    // hold stability: D3 arrives while index 1 is unacked
    step(1, 4'b0010, 0, 4'b1_01_0, 4'b1_01_0);
    step(1, 4'b1000, 0, 4'b1_01_0, 4'b1_01_0);
    step(1, 4'b0000, 0, 4'b1_01_0, 4'b1_01_0);
    step(1, 4'b0000, 1, 4'b1_11_0, 4'b1_11_0);
    step(1, 4'b0010, 0, 4'b1_11_0, 4'b1_11_0);   // P=1010, V=1

    // asynchronous reset mid-handshake, checked before any clock edge
    RST = 1'b1; G = 1'b0; {D3, D2, D1, D0} = 4'b0000; ACK = 1'b0;
    #1;
    chk("async_rst_fx", step_no, {fx_v, fx_a1, fx_a0, fx_ovf}, 4'b0000);
    chk("async_rst_rr", step_no, {rr_v, rr_a1, rr_a0, rr_ovf}, 4'b0000);
    @(posedge CLK);
    #2 RST = 1'b0;

    // idle after reset; ACK with V=0 does nothing
    step(1, 4'b0000, 0, 4'b0_00_0, 4'b0_00_0);
    step(1, 4'b0000, 1, 4'b0_00_0, 4'b0_00_0);
    // enable gating, then G=0 does not block the ack
    step(0, 4'b0100, 0, 4'b0_00_0, 4'b0_00_0);
    step(0, 4'b0100, 0, 4'b0_00_0, 4'b0_00_0);
    step(0, 4'b0100, 0, 4'b0_00_0, 4'b0_00_0);
    step(1, 4'b0100, 0, 4'b1_10_0, 4'b1_10_0);
    step(0, 4'b0000, 1, 4'b0_10_0, 4'b0_10_0);
    // overflow on second cycle of held D1; re-request on ack edge
    step(1, 4'b0010, 0, 4'b1_01_0, 4'b1_01_0);
    step(1, 4'b0010, 0, 4'b1_01_1, 4'b1_01_1);
    step(1, 4'b0000, 0, 4'b1_01_0, 4'b1_01_0);
    step(1, 4'b0010, 1, 4'b1_01_0, 4'b1_01_0);
    step(1, 4'b0000, 1, 4'b0_01_0, 4'b0_01_0);
    // D0 and D2 held with ACK: rr alternates, fixed keeps granting 2
    step(1, 4'b0101, 1, 4'b1_10_0, 4'b1_10_0);
    step(1, 4'b0101, 1, 4'b1_10_1, 4'b1_00_1);
    step(1, 4'b0101, 1, 4'b1_10_1, 4'b1_10_1);
    step(1, 4'b0101, 1, 4'b1_10_1, 4'b1_00_1);
    step(1, 4'b0000, 1, 4'b1_00_0, 4'b1_10_0);
    step(1, 4'b0000, 1, 4'b0_00_0, 4'b0_10_0);

    G = 1'b0; {D3, D2, D1, D0} = 4'b0000; ACK = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "timeout");
  end

endmodule
